// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that serialises register-level I2C requests onto the
// Avalon register port of an I2C master, polling its busy flag around each access.
module i2c_master_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*8-1:0]  req_dev_addr,
    input  logic [NUM_REQ*16-1:0] req_sub_addr,
    input  logic [NUM_REQ*16-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]    req_data_2b,
    input  logic [NUM_REQ-1:0]    req_sub_2b,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [15:0]           rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic                  m_read,
    output logic                  m_write,
    output logic                  m_address,
    output logic [31:0]           m_writedata,
    input  logic [31:0]           m_readdata
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StPreRd, StPreWait, StWrData, StWrAddr, StPostRd, StPostWait, StResp
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   owner_q, owner_d, last_q, last_d;
    logic [7:0]        dev_q, dev_d;
    logic [15:0]       sub_q, sub_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic              d2b_q, d2b_d, s2b_q, s2b_d, err_q, err_d, tmo_q, tmo_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [7:0]        dev_arr   [NUM_REQ];
    logic [15:0]       sub_arr   [NUM_REQ];
    logic [15:0]       wdata_arr [NUM_REQ];
    logic              grant_found;
    logic [IdxW-1:0]   grant_idx;
    logic [NUM_REQ-1:0] ready_raw;
    int unsigned       cand;
    logic              unused_rdata;

    assign unused_rdata = ^m_readdata[31:18];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign dev_arr[g]   = req_dev_addr[8*g +: 8];
        assign sub_arr[g]   = req_sub_addr[16*g +: 16];
        assign wdata_arr[g] = req_wdata[16*g +: 16];
    end

    // Search starts one past the last owner so every waiting requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[IdxW'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = IdxW'(cand);
            end
        end
    end

    // Accept pulse is combinational with the grant, so it must be masked while in reset.
    assign req_ready = ready_raw & {NUM_REQ{reset_n}};

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        dev_d       = dev_q;
        sub_d       = sub_q;
        wdata_d     = wdata_q;
        d2b_d       = d2b_q;
        s2b_d       = s2b_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        cnt_d       = '0;
        ready_raw   = '0;
        rsp_valid   = '0;
        rsp_rdata   = 16'h0;
        rsp_error   = 1'b0;
        rsp_timeout = 1'b0;
        m_read      = 1'b0;
        m_write     = 1'b0;
        m_address   = 1'b0;
        m_writedata = 32'h0;

        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    ready_raw[grant_idx] = 1'b1;
                    owner_d = grant_idx;
                    dev_d   = dev_arr[grant_idx];
                    sub_d   = sub_arr[grant_idx];
                    wdata_d = wdata_arr[grant_idx];
                    d2b_d   = req_data_2b[grant_idx];
                    s2b_d   = req_sub_2b[grant_idx];
                    rdata_d = 16'h0;
                    err_d   = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = StPreRd;
                end
            end
            StPreRd, StPostRd: begin
                m_read  = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = (state_q == StPreRd) ? StPreWait : StPostWait;
            end
            StPreWait: begin
                cnt_d = cnt_q + 1'b1;
                if (m_readdata[16]) begin
                    state_d = StPreRd;
                end else begin
                    state_d = dev_q[0] ? StWrAddr : StWrData;
                end
            end
            StWrData: begin
                m_write     = 1'b1;
                m_writedata = {16'h0, wdata_q};
                state_d     = StWrAddr;
            end
            StWrAddr: begin
                m_write     = 1'b1;
                m_address   = 1'b1;
                m_writedata = {6'h0, s2b_q, d2b_q, dev_q, sub_q};
                state_d     = StPostRd;
            end
            StPostWait: begin
                cnt_d = cnt_q + 1'b1;
                if (m_readdata[16]) begin
                    state_d = StPostRd;
                end else begin
                    rdata_d = m_readdata[15:0];
                    err_d   = m_readdata[17];
                    state_d = StResp;
                end
            end
            StResp: begin
                rsp_valid[owner_q] = 1'b1;
                rsp_rdata   = rdata_q;
                rsp_error   = err_q;
                rsp_timeout = tmo_q;
                last_d      = owner_q;
                state_d     = StIdle;
            end
        endcase

        // Timeout overrides whatever the polling states decided.
        if ((state_q == StPreRd || state_q == StPreWait || state_q == StPostRd ||
             state_q == StPostWait) && cnt_q == CntLast) begin
            state_d = StResp;
            cnt_d   = '0;
            rdata_d = 16'h0;
            err_d   = 1'b1;
            tmo_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= IdxW'(NUM_REQ - 1);
            dev_q   <= 8'h0;
            sub_q   <= 16'h0;
            wdata_q <= 16'h0;
            d2b_q   <= 1'b0;
            s2b_q   <= 1'b0;
            rdata_q <= 16'h0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            dev_q   <= dev_d;
            sub_q   <= sub_d;
            wdata_q <= wdata_d;
            d2b_q   <= d2b_d;
            s2b_q   <= s2b_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: doc/i2c_master_arbiter.md
I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters, legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000, is the maximum clk cycles spent polling busy before abort.
REQ-003 Port clk, input, 1: single clock for all logic.
REQ-004 Port reset_n, input, 1: asynchronous active-low reset.
REQ-005 Port req_valid, input, NUM_REQ: request pending per requester; held until accepted.
REQ-006 Port req_ready, output, NUM_REQ: one-cycle accept pulse, one-hot.
REQ-007 Port req_dev_addr, input, NUM_REQ*8: device address, lsb 1 = read; slice i = [8i+7:8i].
REQ-008 Port req_sub_addr, input, NUM_REQ*16: sub address; slice i = [16i+15:16i].
REQ-009 Port req_wdata, input, NUM_REQ*16: write data; slice i = [16i+15:16i].
REQ-010 Port req_data_2b, input, NUM_REQ: data size 2 bytes when 1.
REQ-011 Port req_sub_2b, input, NUM_REQ: sub address size 2 bytes when 1.
REQ-012 Port rsp_valid, output, NUM_REQ: one-cycle completion pulse to the owning requester.
REQ-013 Port rsp_rdata, output, 16: read data, valid with rsp_valid.
REQ-014 Port rsp_error, output, 1: no-ack or timeout, valid with rsp_valid.
REQ-015 Port rsp_timeout, output, 1: abort caused by timeout, valid with rsp_valid.
REQ-016 Ports m_read, m_write, outputs, 1 each; m_address, output, 1; m_writedata, output, 32; m_readdata, input, 32: avalon master to the i2c master register port.

Function
REQ-017 States: IDLE, PRE_RD, PRE_WAIT, WR_DATA, WR_ADDR, POST_RD, POST_WAIT, RESP.
REQ-018 IDLE: if any req_valid, grant round-robin starting at index (last_grant+1) mod NUM_REQ; pulse req_ready for the winner; latch its fields; go to PRE_RD in the same edge.
REQ-019 PRE_RD/POST_RD: assert m_read=1, m_address=0 for exactly one cycle, then go to the matching _WAIT state.
REQ-020 _WAIT: sample m_readdata in the cycle after m_read (one-cycle read latency); bit16=1 returns to the matching _RD; bit16=0 advances.
REQ-021 PRE_WAIT with busy=0: go to WR_DATA if dev_addr[0]=0, else WR_ADDR.
REQ-022 WR_DATA: one cycle m_write=1, m_address=0, m_writedata={16'h0, wdata}; then WR_ADDR.
REQ-023 WR_ADDR: one cycle m_write=1, m_address=1, m_writedata={6'h0, sub_2b, data_2b, dev_addr, sub_addr}; then POST_RD.
REQ-024 POST_WAIT with busy=0: latch rdata=m_readdata[15:0] and error=m_readdata[17]; go to RESP.
REQ-025 RESP: one cycle; rsp_valid[owner]=1; rsp_rdata, rsp_error and rsp_timeout drive latched values; last_grant=owner; go to IDLE.
REQ-026 m_read and m_write shall never be asserted together; both 0 outside the states above.
REQ-027 Timeout counter clears on entry to PRE_RD from IDLE and on entry to POST_RD from WR_ADDR; increments every cycle in the _RD/_WAIT states; at TIMEOUT_CYCLES go to RESP with rsp_error=1, rsp_timeout=1, rsp_rdata=0.
REQ-028 Requests arriving during a transaction wait; req_valid deasserted before accept is dropped without response.
REQ-029 Minimum latency, write with master idle on first poll: accept to rsp_valid = 7 cycles plus I2C busy time.
REQ-030 Minimum latency, read: 6 cycles plus I2C busy time.

Reset
REQ-031 reset_n low asynchronously forces: state=IDLE, last_grant=NUM_REQ-1, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, rsp_timeout=0, m_read=0, m_write=0, m_address=0, m_writedata=0, counter=0.
REQ-032 Reset mid-transaction abandons it; no rsp_valid is issued for it after release.

Verification
REQ-033 Write: req 0 dev 8'hA0, sub 16'h0012, wdata 16'h00AB, both sizes 0 -> m_writedata 32'h000000AB to address 0, then 32'h00A00012 to address 1, then rsp_valid[0] with rsp_error=0.
REQ-034 Read: req 2 dev 8'hA1, sub_2b=1, data_2b=1, sub 16'h1234; model returns 32'h0000BEEF when not busy -> address 1 gets 32'h03A11234, no data write, rsp_rdata=16'hBEEF.
REQ-035 Arbitration: all four req_valid held high -> grant order 0,1,2,3,0; no requester served twice while another waits.
REQ-036 No-ack: model returns bit17=1 at completion -> rsp_error=1, rsp_timeout=0.
REQ-037 Timeout: TIMEOUT_CYCLES=50, model holds busy forever -> rsp_error=1, rsp_timeout=1 within 50 cycles of the last counter clear.
REQ-038 Reset asserted during POST_WAIT -> all outputs 0 immediately; no rsp_valid after release; next grant goes to index 0.
